// File: rtl/sb_rx_frame_ctrl_if.sv
// Sideband RX bundle: deserializer byte side plus the FWFT payload output toward the decoder.
// The master modport is the frame controller; slave is the surrounding logic.
interface sb_rx_frame_ctrl_if;
  logic       des_en;
  logic [7:0] des_data;
  logic       des_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output des_en,
    input  des_data,
    input  des_valid,
    output out_data,
    output out_last,
    output out_err,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  des_en,
    output des_data,
    output des_valid,
    input  out_data,
    input  out_last,
    input  out_err,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sb_rx_frame_ctrl.sv
// Sideband RX frame controller: de-stuffs DLE/STX..DLE/ETX frames, enforces length and timeout
// limits, and queues payload bytes (plus abort markers) in a small first-word-fall-through FIFO.
module sb_rx_frame_ctrl #(
  parameter logic [7:0]  DLE        = 8'hFE,
  parameter logic [7:0]  STX        = 8'h05,
  parameter logic [7:0]  ETX        = 8'h40,
  parameter int unsigned MAX_LEN    = 32,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_rx_enable,
  sb_rx_frame_ctrl_if.master        bus,
  output logic                      o_frame_act,
  output logic                      o_err_pulse
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned LenW = $clog2(MAX_LEN + 2);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [LenW-1:0] LenMax  = LenW'(MAX_LEN);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SOF_DLE = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] PAY_DLE = 2'd3;

  // FIFO entry layout: {err, last, data}
  localparam logic [9:0] Marker = {1'b1, 1'b1, 8'h00};

  logic [1:0]      r_state;
  logic [LenW-1:0] r_len;
  logic            r_stg_vld;
  logic [7:0]      r_stg_data;
  logic            r_pend;
  logic [TmoW-1:0] r_tmo;
  logic            r_des_en;
  logic            r_err_pulse;
  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_cnt;

  logic [1:0]      w_state_nxt;
  logic [LenW-1:0] w_len_nxt;
  logic            w_stg_vld_nxt;
  logic [7:0]      w_stg_data_nxt;
  logic            w_pend_nxt;
  logic            w_err;
  logic            w_restart;
  logic            w_pay;
  logic [7:0]      w_pay_byte;
  logic            w_push;
  logic [9:0]      w_push_entry;
  logic            w_pop;
  logic            w_can_push;
  logic            w_in_frame;
  logic            w_tmo_hit;
  logic            w_out_valid;

  assign w_in_frame  = (r_state == PAYLOAD) || (r_state == PAY_DLE);
  assign w_tmo_hit   = w_in_frame && (r_tmo == TmoMax);
  assign w_out_valid = (r_cnt != '0);
  assign w_pop       = w_out_valid && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_can_push  = (r_cnt != FullCnt) || w_pop;

  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_stg_vld_nxt  = r_stg_vld;
    w_stg_data_nxt = r_stg_data;
    w_pend_nxt     = r_pend;
    w_err          = 1'b0;
    w_restart      = 1'b0;
    w_pay          = 1'b0;
    w_pay_byte     = bus.des_data;
    w_push         = 1'b0;
    w_push_entry   = '0;

    if (r_pend && w_can_push) begin
      w_push       = 1'b1;
      w_push_entry = Marker;
      w_pend_nxt   = 1'b0;
    end

    if (!i_rx_enable) begin
      w_state_nxt   = IDLE;
      w_stg_vld_nxt = 1'b0;
      w_len_nxt     = '0;
      w_err         = w_in_frame;
    end else if (w_tmo_hit) begin
      w_err = 1'b1;
    end else if (bus.des_valid) begin
      unique case (r_state)
        IDLE: begin
          // No new frame may start until a pending abort marker has been queued.
          if (bus.des_data == DLE && !r_pend) w_state_nxt = SOF_DLE;
        end
        SOF_DLE: begin
          if (bus.des_data == STX) begin
            w_state_nxt   = PAYLOAD;
            w_len_nxt     = '0;
            w_stg_vld_nxt = 1'b0;
          end else if (bus.des_data != DLE) begin
            w_state_nxt = IDLE;
          end
        end
        PAYLOAD: begin
          if (bus.des_data == DLE) w_state_nxt = PAY_DLE;
          else                     w_pay       = 1'b1;
        end
        PAY_DLE: begin
          if (bus.des_data == DLE) begin
            w_pay       = 1'b1;
            w_pay_byte  = DLE;
            w_state_nxt = PAYLOAD;
          end else if (bus.des_data == ETX) begin
            if (w_can_push) begin
              w_push        = 1'b1;
              w_push_entry  = {1'b0, 1'b1, (r_stg_vld ? r_stg_data : 8'h00)};
              w_state_nxt   = IDLE;
              w_stg_vld_nxt = 1'b0;
              w_len_nxt     = '0;
            end else begin
              w_err = 1'b1;
            end
          end else begin
            w_err     = 1'b1;
            w_restart = (bus.des_data == STX);
          end
        end
      endcase
    end

    // The staged byte is committed only once its successor proves it is not the last one.
    if (w_pay) begin
      if (r_len == LenMax || (r_stg_vld && !w_can_push)) begin
        w_err = 1'b1;
      end else begin
        if (r_stg_vld) begin
          w_push       = 1'b1;
          w_push_entry = {1'b0, 1'b0, r_stg_data};
        end
        w_stg_data_nxt = w_pay_byte;
        w_stg_vld_nxt  = 1'b1;
        w_len_nxt      = r_len + LenW'(1);
      end
    end

    if (w_err) begin
      w_stg_vld_nxt = 1'b0;
      w_len_nxt     = '0;
      w_state_nxt   = IDLE;
      if (!w_push && w_can_push) begin
        w_push       = 1'b1;
        w_push_entry = Marker;
      end else begin
        w_pend_nxt = 1'b1;
      end
      if (w_restart && !w_pend_nxt) w_state_nxt = PAYLOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_stg_vld   <= 1'b0;
      r_stg_data  <= 8'h00;
      r_pend      <= 1'b0;
      r_tmo       <= '0;
      r_des_en    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_stg_vld   <= w_stg_vld_nxt;
      r_stg_data  <= w_stg_data_nxt;
      r_pend      <= w_pend_nxt;
      r_des_en    <= i_rx_enable;
      r_err_pulse <= w_err;
      if (!w_in_frame || bus.des_valid || (w_state_nxt != r_state)) begin
        r_tmo <= '0;
      end else if (r_tmo != TmoMax) begin
        r_tmo <= r_tmo + TmoW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CntW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CntW'(1);
    end
  end

  assign bus.des_en    = r_des_en;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? r_mem[r_rptr][7:0] : 8'h00;
  assign bus.out_last  = w_out_valid & r_mem[r_rptr][8];
  assign bus.out_err   = w_out_valid & r_mem[r_rptr][9];
  assign o_frame_act   = w_in_frame;
  assign o_err_pulse   = r_err_pulse;

endmodule

// File: tb/tb_sb_rx_frame_ctrl.sv
// Directed bench for sb_rx_frame_ctrl: framing, de-stuffing, timeout, overflow, length and abort cases.
module tb_sb_rx_frame_ctrl;
  localparam int unsigned MaxLen  = 12;
  localparam int unsigned Timeout = 16;
  localparam int unsigned Depth   = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_enable;
  logic frame_act;
  logic err_pulse;

  sb_rx_frame_ctrl_if bus ();

  sb_rx_frame_ctrl #(
    .MAX_LEN   (MaxLen),
    .TIMEOUT   (Timeout),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx_enable(rx_enable),
    .bus        (bus),
    .o_frame_act(frame_act),
    .o_err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int base;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  // Entries popped from the FIFO and error pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (err_pulse === 1'b1) err_cnt <= err_cnt + 1;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      got_q.push_back({bus.out_err, bus.out_last, bus.out_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.des_data  = b;
    bus.des_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.des_valid = 1'b0;
  endtask

  task automatic compare_q(input string tag);
    check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " des_en"},    32'(bus.des_en),    32'h0);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'h0);
    check({tag, " out_data"},  32'(bus.out_data),  32'h0);
    check({tag, " out_last"},  32'(bus.out_last),  32'h0);
    check({tag, " out_err"},   32'(bus.out_err),   32'h0);
    check({tag, " frame_act"}, 32'(frame_act),     32'h0);
    check({tag, " err_pulse"}, 32'(err_pulse),     32'h0);
  endtask

  initial begin
    rst_n         = 1'b1;
    rx_enable     = 1'b0;
    bus.des_data  = 8'h00;
    bus.des_valid = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    #20 rst_n = 1'b1;
    rx_enable     = 1'b1;
    bus.out_ready = 1'b1;
    tick(2);
    check("des_en follows rx_enable", 32'(bus.des_en), 32'h1);

    // Plain frame
    send(8'hFE); send(8'h05);
    check("frame_act in payload", 32'(frame_act), 32'h1);
    send(8'h11); send(8'h22); send(8'hFE); send(8'h40);
    tick(4);
    check("frame_act after ETX", 32'(frame_act), 32'h0);
    check("plain err_cnt", 32'(err_cnt), 32'd0);
    exp_q.push_back(10'h011); exp_q.push_back(10'h122);
    compare_q("plain");

    // De-stuffed DLE
    send(8'hFE); send(8'h05); send(8'hFE); send(8'hFE);
    send(8'h33); send(8'hFE); send(8'h40);
    tick(4);
    exp_q.push_back(10'h0FE); exp_q.push_back(10'h133);
    compare_q("stuffed");

    // Empty frame
    send(8'hFE); send(8'h05); send(8'hFE); send(8'h40);
    tick(4);
    exp_q.push_back(10'h100);
    compare_q("empty");
    check("no errors so far", 32'(err_cnt), 32'd0);

    // Timeout inside a frame
    base = err_cnt;
    send(8'hFE); send(8'h05); send(8'hAA);
    tick(Timeout / 2);
    check("no early timeout", 32'(err_cnt), 32'(base));
    for (int i = 0; i < 3 * Timeout && err_cnt == base; i++) tick(1);
    check("timeout err_pulse", 32'(err_cnt), 32'(base + 1));
    check("timeout leaves frame", 32'(frame_act), 32'h0);
    tick(4);
    exp_q.push_back(10'h300);
    compare_q("timeout");

    // Overflow with the consumer stalled
    bus.out_ready = 1'b0;
    base = err_cnt;
    send(8'hFE); send(8'h05);
    for (int i = 1; i <= Depth + 2; i++) send(8'(i));
    tick(2);
    check("overflow err_pulse", 32'(err_cnt), 32'(base + 1));
    check("overflow head valid", 32'(bus.out_valid), 32'h1);
    check("overflow head data", 32'(bus.out_data), 32'h01);
    // Frame while the marker is still pending must be ignored.
    send(8'hFE); send(8'h05); send(8'h55); send(8'hFE); send(8'h40);
    tick(2);
    check("pending blocks frame", 32'(frame_act), 32'h0);
    check("no pops while stalled", 32'(got_q.size()), 32'd0);
    bus.out_ready = 1'b1;
    tick(Depth + 6);
    for (int i = 1; i <= Depth; i++) exp_q.push_back(10'(i));
    exp_q.push_back(10'h300);
    compare_q("overflow");
    send(8'hFE); send(8'h05); send(8'h66); send(8'hFE); send(8'h40);
    tick(4);
    exp_q.push_back(10'h166);
    compare_q("after overflow");
    check("overflow single error", 32'(err_cnt), 32'(base + 1));

    // Length limit: byte MaxLen+1 aborts
    base = err_cnt;
    send(8'hFE); send(8'h05);
    for (int i = 0; i <= MaxLen; i++) send(8'(8'h20 + i));
    tick(4);
    check("maxlen err_pulse", 32'(err_cnt), 32'(base + 1));
    for (int i = 0; i < MaxLen - 1; i++) exp_q.push_back(10'(8'h20 + i));
    exp_q.push_back(10'h300);
    compare_q("maxlen");

    // rx_enable dropped mid-frame
    base = err_cnt;
    send(8'hFE); send(8'h05); send(8'h77);
    rx_enable = 1'b0;
    tick(1);
    check("des_en low", 32'(bus.des_en), 32'h0);
    rx_enable = 1'b1;
    tick(4);
    check("rx drop err_pulse", 32'(err_cnt), 32'(base + 1));
    exp_q.push_back(10'h300);
    compare_q("rx drop");

    // Bad escape code
    base = err_cnt;
    send(8'hFE); send(8'h05); send(8'h88); send(8'hFE); send(8'h99);
    tick(4);
    check("bad code err_pulse", 32'(err_cnt), 32'(base + 1));
    exp_q.push_back(10'h300);
    compare_q("bad code");

    // DLE STX mid-frame: abort then restart
    base = err_cnt;
    send(8'hFE); send(8'h05); send(8'h11); send(8'hFE); send(8'h05);
    check("restart frame_act", 32'(frame_act), 32'h1);
    send(8'h22); send(8'hFE); send(8'h40);
    tick(4);
    check("restart err_pulse", 32'(err_cnt), 32'(base + 1));
    exp_q.push_back(10'h300); exp_q.push_back(10'h122);
    compare_q("restart");

    // Asynchronous reset mid-frame
    bus.out_ready = 1'b0;
    send(8'hFE); send(8'h05); send(8'h01); send(8'h02); send(8'h03);
    tick(2);
    check("pre-reset valid", 32'(bus.out_valid), 32'h1);
    check("pre-reset frame_act", 32'(frame_act), 32'h1);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("async reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
